// File: rtl/snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : snap_capture_ctrl
//  Description : Arms on a software start edge, optionally waits for an
//                external trigger, then writes 2**ADDR_W samples into a
//                snapshot BRAM. Optional macro SNAP_TIMESTAMP_EN adds a
//                free-running timestamp latched when word 0 is accepted.
//  Revision    : 1.0 - initial release
// ============================================================================
module snap_capture_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic              user_clk,
    input  logic              user_rst_n,
    input  logic [31:0]       ctrl_reg,
    input  logic [DATA_W-1:0] din,
    input  logic              din_valid,
    input  logic              ext_trig,
    output logic [ADDR_W-1:0] bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              bram_we,
    output logic [31:0]       status,
    output logic [31:0]       trig_ts
);

    // Word count must fit below the done/busy/armed flags in status.
    localparam logic [ADDR_W:0] C_LAST_ADDR = {1'b0, {ADDR_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic            r_ctrl0_d;
    logic            r_hist_vld;
    logic [ADDR_W:0] r_cnt;
    logic            w_start_edge;
    logic            w_qv;
    logic            w_wr;
    logic            w_start;
    logic [31:0]     w_status;
    logic            w_unused_ctrl;

    // A start level already present when reset releases is not an edge.
    assign w_start_edge  = ctrl_reg[0] & ~r_ctrl0_d & r_hist_vld;
    assign w_qv          = din_valid | ctrl_reg[2];
    assign w_unused_ctrl = ^ctrl_reg[31:3];

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE: begin
                if (w_start_edge) begin
                    w_start     = 1'b1;
                    w_state_nxt = ctrl_reg[1] ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (ext_trig && w_qv) begin
                    w_wr        = 1'b1;
                    w_state_nxt = ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (w_qv) begin
                    w_wr = 1'b1;
                    if (r_cnt == C_LAST_ADDR) begin
                        w_state_nxt = ST_DONE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        w_status             = '0;
        w_status[31]         = (r_state == ST_DONE);
        w_status[30]         = (r_state == ST_ARMED) || (r_state == ST_CAPTURE);
        w_status[29]         = (r_state == ST_ARMED);
        w_status[ADDR_W:0]   = r_cnt;
    end

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_ctrl0_d  <= 1'b0;
            r_hist_vld <= 1'b0;
            r_cnt      <= '0;
            bram_we    <= 1'b0;
            bram_addr  <= '0;
            bram_din   <= '0;
            status     <= '0;
        end else begin
            r_ctrl0_d  <= ctrl_reg[0];
            r_hist_vld <= 1'b1;
            if (w_start) begin
                r_cnt <= '0;
            end else if (w_wr) begin
                r_cnt <= r_cnt + 1'b1;
            end
            bram_we <= w_wr;
            if (w_wr) begin
                bram_addr <= r_cnt[ADDR_W-1:0];
                bram_din  <= din;
            end
            status <= w_status;
        end
    end

`ifdef SNAP_TIMESTAMP_EN
    logic [31:0] r_ts_cnt;
    logic [31:0] r_trig_ts;

    always_ff @(posedge user_clk or negedge user_rst_n) begin
        if (!user_rst_n) begin
            r_ts_cnt  <= '0;
            r_trig_ts <= '0;
        end else begin
            r_ts_cnt <= r_ts_cnt + 32'd1;
            if (w_wr && (r_cnt == '0)) begin
                r_trig_ts <= r_ts_cnt;
            end
        end
    end

    assign trig_ts = r_trig_ts;
`else
    assign trig_ts = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_snap_capture_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_snap_capture_ctrl
//  Description : Directed self-checking bench for snap_capture_ctrl, ADDR_W=4.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_snap_capture_ctrl;

    localparam int ADDR_W = 4;
    localparam int DATA_W = 32;

    logic              user_clk;
    logic              user_rst_n;
    logic [31:0]       ctrl_reg;
    logic [DATA_W-1:0] din;
    logic              din_valid;
    logic              ext_trig;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [31:0]       status;
    logic [31:0]       trig_ts;

    int total;
    int bad;

    snap_capture_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .user_clk   (user_clk),
        .user_rst_n (user_rst_n),
        .ctrl_reg   (ctrl_reg),
        .din        (din),
        .din_valid  (din_valid),
        .ext_trig   (ext_trig),
        .bram_addr  (bram_addr),
        .bram_din   (bram_din),
        .bram_we    (bram_we),
        .status     (status),
        .trig_ts    (trig_ts)
    );

    initial user_clk = 1'b0;
    always #5 user_clk = ~user_clk;

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic step();
        @(posedge user_clk);
        #1;
    endtask

    task automatic test_reset();
        user_rst_n = 1'b0;
        ctrl_reg   = 32'd0;
        din        = 32'hDEAD_BEEF;
        din_valid  = 1'b1;
        ext_trig   = 1'b1;
        step();
        step();
        total++;
        if (bram_we !== 1'b0) begin
            bad++; $display("FAIL reset_we: got %b want 0", bram_we);
        end
        total++;
        if (status !== 32'd0) begin
            bad++; $display("FAIL reset_status: got %h want 0", status);
        end
        total++;
        if (bram_addr !== 4'd0 || bram_din !== 32'd0 || trig_ts !== 32'd0) begin
            bad++; $display("FAIL reset_outs: addr=%0d din=%h ts=%h want all 0", bram_addr, bram_din, trig_ts);
        end
        user_rst_n = 1'b1;
        ext_trig   = 1'b0;
        step();
        step();
        total++;
        if (bram_we !== 1'b0 || status !== 32'd0) begin
            bad++; $display("FAIL reset_idle: we=%b status=%h want 0/0", bram_we, status);
        end
    endtask

    task automatic test_immediate();
        ctrl_reg  = 32'd0;
        din_valid = 1'b1;
        step();
        ctrl_reg = 32'd1;
        step();
        for (int k = 0; k < 16; k++) begin
            din = 32'hC0DE_0000 + k;
            step();
            total++;
            if (bram_we !== 1'b1 || bram_addr !== k[3:0] || bram_din !== (32'hC0DE_0000 + k)) begin
                bad++; $display("FAIL imm_write%0d: we=%b addr=%0d din=%h want 1/%0d/%h",
                                k, bram_we, bram_addr, bram_din, k, 32'hC0DE_0000 + k);
            end
            if (k == 5) begin
                total++;
                if (status[30] !== 1'b1 || status[4:0] !== 5'd5) begin
                    bad++; $display("FAIL imm_busy: status=%h want busy=1 count=5", status);
                end
            end
        end
        step();
        total++;
        if (bram_we !== 1'b0 || bram_addr !== 4'd15) begin
            bad++; $display("FAIL imm_stop: we=%b addr=%0d want 0/15", bram_we, bram_addr);
        end
        total++;
        if (status !== 32'h8000_0010) begin
            bad++; $display("FAIL imm_done: status=%h want 80000010", status);
        end
    endtask

    task automatic test_triggered();
        ctrl_reg  = 32'd0;
        din_valid = 1'b1;
        ext_trig  = 1'b0;
        step();
        ctrl_reg = 32'd3;
        step();
        step();
        total++;
        if (bram_we !== 1'b0) begin
            bad++; $display("FAIL trig_nowrite: we=%b want 0", bram_we);
        end
        step();
        total++;
        if (status !== 32'h6000_0000) begin
            bad++; $display("FAIL trig_armed: status=%h want 60000000", status);
        end
        din_valid = 1'b0;
        ext_trig  = 1'b1;
        step();
        total++;
        if (bram_we !== 1'b0) begin
            bad++; $display("FAIL trig_noqv: we=%b want 0", bram_we);
        end
        din_valid = 1'b1;
        din       = 32'h7716_0000;
        step();
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 4'd0 || bram_din !== 32'h7716_0000) begin
            bad++; $display("FAIL trig_first: we=%b addr=%0d din=%h want 1/0/77160000", bram_we, bram_addr, bram_din);
        end
        ext_trig = 1'b0;
        for (int k = 1; k < 16; k++) begin
            din = 32'h7716_0000 + k;
            step();
            total++;
            if (bram_we !== 1'b1 || bram_addr !== k[3:0] || bram_din !== (32'h7716_0000 + k)) begin
                bad++; $display("FAIL trig_write%0d: we=%b addr=%0d din=%h", k, bram_we, bram_addr, bram_din);
            end
        end
        step();
        total++;
        if (bram_we !== 1'b0 || status !== 32'h8000_0010) begin
            bad++; $display("FAIL trig_done: we=%b status=%h want 0/80000010", bram_we, status);
        end
`ifndef SNAP_TIMESTAMP_EN
        total++;
        if (trig_ts !== 32'd0) begin
            bad++; $display("FAIL trig_ts_tied: got %h want 0", trig_ts);
        end
`endif
    endtask

    task automatic test_gapped(input logic force_we);
        int n_steps;
        ctrl_reg  = 32'd0;
        din_valid = 1'b1;
        step();
        ctrl_reg  = force_we ? 32'd5 : 32'd1;
        step();
        n_steps = force_we ? 16 : 32;
        for (int k = 1; k <= n_steps; k++) begin
            din_valid = force_we ? 1'b0 : (k % 2 == 0);
            din       = 32'h6A00_0000 + k;
            step();
            total++;
            if (force_we || (k % 2 == 0)) begin
                if (bram_we !== 1'b1 || bram_addr !== (force_we ? k - 1 : k / 2 - 1) ||
                    bram_din !== (32'h6A00_0000 + k)) begin
                    bad++; $display("FAIL gap%0d_write%0d: we=%b addr=%0d din=%h",
                                    force_we, k, bram_we, bram_addr, bram_din);
                end
            end else begin
                if (bram_we !== 1'b0) begin
                    bad++; $display("FAIL gap_idle%0d: we=%b want 0", k, bram_we);
                end
            end
        end
        din_valid = 1'b1;
        step();
        total++;
        if (bram_we !== 1'b0 || status !== 32'h8000_0010) begin
            bad++; $display("FAIL gap%0d_done: we=%b status=%h want 0/80000010", force_we, bram_we, status);
        end
    endtask

    task automatic test_repulse_and_reset();
        ctrl_reg  = 32'd0;
        din_valid = 1'b1;
        step();
        ctrl_reg = 32'd1;
        step();
        for (int k = 0; k < 16; k++) begin
            ctrl_reg = (k == 5) ? 32'd0 : 32'd1;
            din      = 32'h5EED_0000 + k;
            step();
            total++;
            if (bram_we !== 1'b1 || bram_addr !== k[3:0] || bram_din !== (32'h5EED_0000 + k)) begin
                bad++; $display("FAIL repulse_write%0d: we=%b addr=%0d din=%h", k, bram_we, bram_addr, bram_din);
            end
        end
        ctrl_reg = 32'd0;
        step();
        total++;
        if (status !== 32'h8000_0010) begin
            bad++; $display("FAIL repulse_done: status=%h want 80000010", status);
        end
        ctrl_reg = 32'd1;
        step();
        din = 32'h0BAD_0000;
        step();
        total++;
        if (bram_we !== 1'b1 || bram_addr !== 4'd0 || status[31] !== 1'b0) begin
            bad++; $display("FAIL restart: we=%b addr=%0d done=%b want 1/0/0", bram_we, bram_addr, status[31]);
        end
        for (int k = 1; k < 7; k++) begin
            step();
        end
        total++;
        if (bram_addr !== 4'd6 || bram_we !== 1'b1) begin
            bad++; $display("FAIL pre_reset: addr=%0d we=%b want 6/1", bram_addr, bram_we);
        end
        user_rst_n = 1'b0;
        #1;
        total++;
        if (bram_we !== 1'b0 || status !== 32'd0) begin
            bad++; $display("FAIL mid_reset: we=%b status=%h want 0/0", bram_we, status);
        end
        step();
        user_rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            step();
            total++;
            if (bram_we !== 1'b0 || status !== 32'd0) begin
                bad++; $display("FAIL post_reset%0d: we=%b status=%h want 0/0", k, bram_we, status);
            end
        end
    endtask

`ifdef SNAP_TIMESTAMP_EN
    task automatic test_timestamp();
        ctrl_reg   = 32'd0;
        din_valid  = 1'b1;
        ext_trig   = 1'b0;
        user_rst_n = 1'b0;
        step();
        user_rst_n = 1'b1;
        for (int n = 0; n < 100; n++) begin
            ctrl_reg = (n >= 1) ? 32'd3 : 32'd0;
            step();
        end
        ext_trig = 1'b1;
        step();
        ext_trig = 1'b0;
        total++;
        if (trig_ts !== 32'd100 || bram_we !== 1'b1) begin
            bad++; $display("FAIL timestamp: ts=%0d we=%b want 100/1", trig_ts, bram_we);
        end
    endtask
`endif

    initial begin
        total      = 0;
        bad        = 0;
        user_rst_n = 1'b0;
        ctrl_reg   = 32'd0;
        din        = 32'd0;
        din_valid  = 1'b0;
        ext_trig   = 1'b0;
        test_reset();
        test_immediate();
        test_triggered();
        test_gapped(1'b0);
        test_gapped(1'b1);
        test_repulse_and_reset();
`ifdef SNAP_TIMESTAMP_EN
        test_timestamp();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
